// File: rtl/ring_output_arbiter_if.sv
// Handshake bundle for one ring-router output port.
// It carries both requester channels, the outgoing link and the buffer status.
interface ring_output_arbiter_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  req0_vld;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  gnt0;
  logic                  req1_vld;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  gnt1;
  logic                  out_send;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic                  even_full;
  logic                  odd_full;

  modport master (
    output req0_vld, req0_data, req1_vld, req1_data, out_ready,
    input  gnt0, gnt1, out_send, out_data, even_full, odd_full
  );

  modport slave (
    input  req0_vld, req0_data, req1_vld, req1_data, out_ready,
    output gnt0, gnt1, out_send, out_data, even_full, odd_full
  );
endinterface

// File: rtl/ring_output_arbiter.sv
// Output-port switch allocator with one single-entry buffer per VC.
// The link reads VC `polarity` while the switch writes VC ~polarity, so the two sides never collide.
module ring_output_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_BIT     = 63
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  polarity,
  ring_output_arbiter_if.slave bus
);

  logic [DATA_WIDTH-1:0] r_buf [2];
  logic [1:0]            r_full;
  logic [1:0]            r_rr;

  logic                  w_wvc;
  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_send;
  logic [DATA_WIDTH-1:0] w_wdata;

  always_comb begin
    w_wvc   = ~polarity;
    w_elig0 = bus.req0_vld && (bus.req0_data[VC_BIT] == w_wvc) && !r_full[w_wvc];
    w_elig1 = bus.req1_vld && (bus.req1_data[VC_BIT] == w_wvc) && !r_full[w_wvc];
    // r_rr[v] names the requester that wins a tie on VC v.
    w_gnt0  = !reset && w_elig0 && (!w_elig1 || !r_rr[w_wvc]);
    w_gnt1  = !reset && w_elig1 && (!w_elig0 ||  r_rr[w_wvc]);
    w_wdata = w_gnt1 ? bus.req1_data : bus.req0_data;
    w_send  = !reset && r_full[polarity];
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.out_send  = w_send;
  assign bus.out_data  = r_full[polarity] ? r_buf[polarity] : '0;
  assign bus.even_full = r_full[0];
  assign bus.odd_full  = r_full[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full   <= '0;
      r_rr     <= '0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
    end else begin
      if (w_send && bus.out_ready) begin
        r_full[polarity] <= 1'b0;
      end
      if (w_gnt0 || w_gnt1) begin
        r_buf[w_wvc]  <= w_wdata;
        r_full[w_wvc] <= 1'b1;
        r_rr[w_wvc]   <= w_gnt0;
      end
    end
  end

endmodule

// File: tb/tb_ring_output_arbiter.sv
// Scenario bench for ring_output_arbiter; expected link packets queue up as grants are expected.
module tb_ring_output_arbiter;
  localparam int DW  = 64;
  localparam int VCB = 63;

  logic clk = 1'b0;
  logic reset;
  logic polarity;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb [$];

  always #5 clk = ~clk;

  ring_output_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  ring_output_arbiter #(.DATA_WIDTH(DW), .VC_BIT(VCB)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .bus      (bus)
  );

  // Samples the link at the falling edge, retires expected packets, then advances one cycle.
  task automatic next_cycle();
    logic [DW-1:0] exp;
    @(negedge clk);
    if (bus.out_send === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_send got %h required no send", bus.out_data);
      end else begin
        exp = sb.pop_front();
        if (bus.out_data !== exp) begin
          errors++;
          $display("FAIL sb_data got %h required %h", bus.out_data, exp);
        end
      end
    end
    @(posedge clk);
    #1;
    polarity = ~polarity;
  endtask

  task automatic align(input logic p);
    if (polarity !== p) next_cycle();
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    polarity      = 1'b0;
    bus.out_ready = 1'b1;
    bus.req0_vld  = 1'b1;
    bus.req0_data = 64'h8000_0000_0000_0001;
    bus.req1_vld  = 1'b0;
    bus.req1_data = '0;
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.out_send !== 1'b0) begin
      errors++;
      $display("FAIL rst_during gnt0=%b out_send=%b required 0 0", bus.gnt0, bus.out_send);
    end
    reset        = 1'b0;
    bus.req0_vld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.out_send, bus.even_full, bus.odd_full} !== 5'b0) begin
        errors++;
        $display("FAIL rst_idle gnt0=%b gnt1=%b send=%b ef=%b of=%b required all 0",
                 bus.gnt0, bus.gnt1, bus.out_send, bus.even_full, bus.odd_full);
      end
    end
  endtask

  task automatic test_single();
    align(1'b0);
    bus.out_ready = 1'b1;
    bus.req0_vld  = 1'b1;
    bus.req0_data = 64'h8000_0000_0000_00A5;
    #1;
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt gnt0=%b gnt1=%b required 1 0", bus.gnt0, bus.gnt1);
    end
    sb.push_back(64'h8000_0000_0000_00A5);
    next_cycle();
    bus.req0_vld = 1'b0;
    #1;
    checks++;
    if (bus.out_send !== 1'b1 || bus.out_data !== 64'h8000_0000_0000_00A5 || bus.odd_full !== 1'b1) begin
      errors++;
      $display("FAIL single_out send=%b data=%h of=%b required 1 80000000000000a5 1",
               bus.out_send, bus.out_data, bus.odd_full);
    end
    next_cycle();
    #1;
    checks++;
    if (bus.odd_full !== 1'b0 || bus.out_send !== 1'b0) begin
      errors++;
      $display("FAIL single_drain of=%b send=%b required 0 0", bus.odd_full, bus.out_send);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] p0 [2];
    logic [DW-1:0] p1 [2];
    int order [3];
    int i0;
    int i1;
    int k;
    p0[0] = 64'h0000_0000_0000_0A0A;
    p0[1] = 64'h0000_0000_0000_0A2A;
    p1[0] = 64'h0000_0000_0000_0B0B;
    p1[1] = 64'h0000_0000_0000_0B2B;
    order[0] = 0;
    order[1] = 1;
    order[2] = 0;
    i0 = 0;
    i1 = 0;
    k  = 0;
    align(1'b1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.req0_vld  = (k < 3);
      bus.req1_vld  = (k < 3);
      bus.req0_data = p0[(i0 > 1) ? 1 : i0];
      bus.req1_data = p1[(i1 > 1) ? 1 : i1];
      #1;
      checks++;
      if (polarity && k < 3) begin
        if ({bus.gnt0, bus.gnt1} !== ((order[k] == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rr_gnt window=%0d gnt0=%b gnt1=%b required winner %0d",
                   k, bus.gnt0, bus.gnt1, order[k]);
        end
        if (order[k] == 0) begin
          sb.push_back(p0[i0]);
          i0++;
        end else begin
          sb.push_back(p1[i1]);
          i1++;
        end
        k++;
      end else if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle gnt0=%b gnt1=%b required 0 0", bus.gnt0, bus.gnt1);
      end
      next_cycle();
    end
    bus.req0_vld = 1'b0;
    bus.req1_vld = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] pc;
    logic [DW-1:0] pd;
    pc = 64'h0000_0000_0000_0C0C;
    pd = 64'h0000_0000_0000_0D0D;
    align(1'b1);
    bus.out_ready = 1'b0;
    bus.req0_vld  = 1'b1;
    bus.req0_data = pc;
    bus.req1_vld  = 1'b0;
    #1;
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL bp_first gnt0=%b required 1", bus.gnt0);
    end
    sb.push_back(pc);
    next_cycle();
    bus.req0_vld  = 1'b0;
    bus.req1_vld  = 1'b1;
    bus.req1_data = pd;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (polarity == 1'b0) begin
        if (bus.out_send !== 1'b1 || bus.out_data !== pc || bus.gnt1 !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold_even send=%b data=%h gnt1=%b required 1 %h 0",
                   bus.out_send, bus.out_data, bus.gnt1, pc);
        end
      end else if (bus.out_send !== 1'b0 || bus.gnt1 !== 1'b0 || bus.even_full !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_odd send=%b gnt1=%b ef=%b required 0 0 1",
                 bus.out_send, bus.gnt1, bus.even_full);
      end
      next_cycle();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.out_send !== 1'b1 || polarity !== 1'b0) begin
      errors++;
      $display("FAIL bp_release send=%b pol=%b required 1 0", bus.out_send, polarity);
    end
    next_cycle();
    #1;
    checks++;
    if (bus.gnt1 !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume gnt1=%b required 1", bus.gnt1);
    end
    sb.push_back(pd);
    next_cycle();
    bus.req1_vld = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (bus.even_full !== 1'b0 || bus.out_send !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained ef=%b send=%b required 0 0", bus.even_full, bus.out_send);
    end
  endtask

  task automatic test_vc_polarity();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.req0_vld  = 1'b1;
      bus.req1_vld  = 1'b1;
      bus.req0_data = {polarity, 63'h11};
      bus.req1_data = {polarity, 63'h22};
      #1;
      checks++;
      if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
        errors++;
        $display("FAIL vcpol_gnt cycle=%0d gnt0=%b gnt1=%b required 0 0", c, bus.gnt0, bus.gnt1);
      end
      next_cycle();
    end
    bus.req0_vld = 1'b0;
    bus.req1_vld = 1'b0;
    #1;
    checks++;
    if (bus.even_full !== 1'b0 || bus.odd_full !== 1'b0) begin
      errors++;
      $display("FAIL vcpol_empty ef=%b of=%b required 0 0", bus.even_full, bus.odd_full);
    end
  endtask

  task automatic test_reset_mid();
    align(1'b0);
    bus.out_ready = 1'b0;
    bus.req0_vld  = 1'b1;
    bus.req0_data = 64'h8000_0000_0000_0E0E;
    #1;
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill gnt0=%b required 1", bus.gnt0);
    end
    next_cycle();
    bus.req0_vld = 1'b0;
    #1;
    checks++;
    if (bus.odd_full !== 1'b1 || bus.out_send !== 1'b1) begin
      errors++;
      $display("FAIL mid_full of=%b send=%b required 1 1", bus.odd_full, bus.out_send);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_send !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_send send=%b required 0", bus.out_send);
    end
    next_cycle();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.odd_full !== 1'b0 || bus.out_send !== 1'b0) begin
      errors++;
      $display("FAIL mid_after of=%b send=%b required 0 0", bus.odd_full, bus.out_send);
    end
    bus.req0_vld  = 1'b1;
    bus.req0_data = 64'h8000_0000_0000_0F00;
    bus.req1_vld  = 1'b1;
    bus.req1_data = 64'h8000_0000_0000_0F11;
    #1;
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_contest gnt0=%b gnt1=%b required 1 0", bus.gnt0, bus.gnt1);
    end
    sb.push_back(64'h8000_0000_0000_0F00);
    next_cycle();
    bus.req0_vld  = 1'b0;
    bus.req1_vld  = 1'b0;
    bus.out_ready = 1'b1;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_vc_polarity();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
